// File: rtl/sample_arbiter_pkg.sv
// Shared types and encodings for the sample arbiter.
//   state_e     : arbiter FSM states
//   src_t       : grant encoding (SRC_NONE / SRC_ADC / SRC_MSP)
//   pick_src()  : priority grant from the preference bit and ready flags
//   cnt_width() : bit-counter width able to hold 0..n
package sample_arbiter_pkg;

    localparam int unsigned SRC_W = 2;

    typedef logic [SRC_W-1:0] src_t;

    localparam src_t SRC_NONE = 2'd0;
    localparam src_t SRC_ADC  = 2'd1;
    localparam src_t SRC_MSP  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Preferred source if ready, else the other one if ready, else none.
    function automatic src_t pick_src(input logic pri_msp, input logic adc_rdy,
                                      input logic msp_rdy);
        src_t sel;
        sel = SRC_NONE;
        if (pri_msp) begin
            if (msp_rdy)      sel = SRC_MSP;
            else if (adc_rdy) sel = SRC_ADC;
        end else begin
            if (adc_rdy)      sel = SRC_ADC;
            else if (msp_rdy) sel = SRC_MSP;
        end
        return sel;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sample_bit_counter.sv
// Per-window sample bit counter with terminal-count detect.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : synchronous clear (window closed)
//   inc_i      : count one forwarded strobe
//   term_o     : count currently equals NUM_BITS-1 (next strobe is the last)
module sample_bit_counter
    import sample_arbiter_pkg::*;
#(
    parameter int unsigned NUM_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic term_o
);

    localparam int unsigned CW = cnt_width(NUM_BITS);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term_o = (count_q == CW'(NUM_BITS - 1));

endmodule

// File: rtl/sample_arbiter.sv
// Arbitrates a serial sample read window between an ADC and an MSP430.
// The grant is taken when the window opens and held until it closes;
// bit strobes are forwarded to the granted source and its data is
// returned combinationally.
//   read_sample_ctl/clk/datain : read responder window, strobe, return bit
//   pri_msp                    : 1 prefers MSP, 0 prefers ADC
//   adc_/msp_ ready,data       : source status and serial bit
//   adc_/msp_ ctl,clk          : source select and forwarded strobe
//   src_sel, busy              : current grant, window in progress
//   err_short, err_over        : sticky short-window / excess-strobe flags
module sample_arbiter
    import sample_arbiter_pkg::*;
#(
    parameter int unsigned NUM_BITS = 16,
    parameter logic        FILL_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             read_sample_ctl,
    input  logic             read_sample_clk,
    output logic             read_sample_datain,
    input  logic             pri_msp,
    input  logic             adc_ready,
    input  logic             msp_ready,
    input  logic             adc_data,
    input  logic             msp_data,
    output logic             adc_ctl,
    output logic             msp_ctl,
    output logic             adc_clk,
    output logic             msp_clk,
    output logic [SRC_W-1:0] src_sel,
    output logic             busy,
    output logic             err_short,
    output logic             err_over
);

    state_e state_q, state_d;
    src_t   src_sel_q, src_sel_d;
    logic   err_short_q, err_short_d;
    logic   err_over_q, err_over_d;
    logic   cnt_clr, cnt_inc, cnt_term;
    logic   sel_bit;

    sample_bit_counter #(
        .NUM_BITS (NUM_BITS)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (reset_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .term_o (cnt_term)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            src_sel_q   <= SRC_NONE;
            err_short_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_sel_q   <= src_sel_d;
            err_short_q <= err_short_d;
            err_over_q  <= err_over_d;
        end
    end

    // Next-state, grant and error flag logic
    always_comb begin
        state_d     = state_q;
        src_sel_d   = src_sel_q;
        err_short_d = err_short_q;
        err_over_d  = err_over_q;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (read_sample_clk) begin
                    err_over_d = 1'b1;
                end
                if (read_sample_ctl) begin
                    // Flags restart with the new window; a strobe on this
                    // very edge is still an ignored strobe.
                    state_d     = ST_ARB;
                    src_sel_d   = pick_src(pri_msp, adc_ready, msp_ready);
                    err_short_d = 1'b0;
                    err_over_d  = read_sample_clk;
                end
            end
            ST_ARB: begin
                if (read_sample_clk) begin
                    err_over_d = 1'b1;
                end
                if (!read_sample_ctl) begin
                    state_d     = ST_IDLE;
                    src_sel_d   = SRC_NONE;
                    err_short_d = 1'b1;
                    cnt_clr     = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_inc = read_sample_clk;
                // A coincident strobe is counted first, so a final strobe
                // with the window falling still completes the window.
                if (read_sample_clk && cnt_term) begin
                    state_d = ST_HOLD;
                end else if (!read_sample_ctl) begin
                    state_d     = ST_IDLE;
                    src_sel_d   = SRC_NONE;
                    err_short_d = 1'b1;
                    cnt_clr     = 1'b1;
                end
            end
            ST_HOLD: begin
                if (read_sample_clk) begin
                    err_over_d = 1'b1;
                end
                if (!read_sample_ctl) begin
                    state_d   = ST_IDLE;
                    src_sel_d = SRC_NONE;
                    cnt_clr   = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                src_sel_d = SRC_NONE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy    = (state_q != ST_IDLE);
        adc_ctl = busy && (src_sel_q == SRC_ADC);
        msp_ctl = busy && (src_sel_q == SRC_MSP);
        adc_clk = (state_q == ST_SHIFT) && (src_sel_q == SRC_ADC) && read_sample_clk;
        msp_clk = (state_q == ST_SHIFT) && (src_sel_q == SRC_MSP) && read_sample_clk;
        case (src_sel_q)
            SRC_ADC: sel_bit = adc_data;
            SRC_MSP: sel_bit = msp_data;
            default: sel_bit = FILL_BIT;
        endcase
        if (state_q == ST_HOLD) begin
            sel_bit = FILL_BIT;
        end
        // Forced low during reset even when FILL_BIT is 1.
        read_sample_datain = reset_n && sel_bit;
    end

    assign src_sel   = src_sel_q;
    assign err_short = err_short_q;
    assign err_over  = err_over_q;

endmodule

// File: tb/tb_sample_arbiter.sv
// Self-checking bench for sample_arbiter: directed window table, hand-written
// corner sequences and randomized windows against a transaction-level model.
module tb_sample_arbiter;
    import sample_arbiter_pkg::*;

    localparam int NB = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       read_sample_ctl, read_sample_clk, read_sample_datain;
    logic       pri_msp, adc_ready, msp_ready, adc_data, msp_data;
    logic       adc_ctl, msp_ctl, adc_clk, msp_clk;
    logic [1:0] src_sel;
    logic       busy, err_short, err_over;

    int n_pass = 0;
    int n_total = 0;

    sample_arbiter #(.NUM_BITS(NB), .FILL_BIT(1'b0)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .read_sample_ctl    (read_sample_ctl),
        .read_sample_clk    (read_sample_clk),
        .read_sample_datain (read_sample_datain),
        .pri_msp            (pri_msp),
        .adc_ready          (adc_ready),
        .msp_ready          (msp_ready),
        .adc_data           (adc_data),
        .msp_data           (msp_data),
        .adc_ctl            (adc_ctl),
        .msp_ctl            (msp_ctl),
        .adc_clk            (adc_clk),
        .msp_clk            (msp_clk),
        .src_sel            (src_sel),
        .busy               (busy),
        .err_short          (err_short),
        .err_over           (err_over)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference grant: preferred source wins if ready, else the other one.
    function automatic logic [1:0] ref_grant(input logic pri, input logic ar, input logic mr);
        logic pref_rdy, oth_rdy;
        logic [1:0] pref_id, oth_id;
        pref_rdy = pri ? mr : ar;
        oth_rdy  = pri ? ar : mr;
        pref_id  = pri ? 2'd2 : 2'd1;
        oth_id   = pri ? 2'd1 : 2'd2;
        if (pref_rdy) return pref_id;
        if (oth_rdy)  return oth_id;
        return 2'd0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_src"},    32'(src_sel), 0);
        chk({tag, "_busy"},   32'(busy), 0);
        chk({tag, "_eshort"}, 32'(err_short), 0);
        chk({tag, "_eover"},  32'(err_over), 0);
        chk({tag, "_actl"},   32'(adc_ctl), 0);
        chk({tag, "_mctl"},   32'(msp_ctl), 0);
        chk({tag, "_aclk"},   32'(adc_clk), 0);
        chk({tag, "_mclk"},   32'(msp_clk), 0);
        chk({tag, "_din"},    32'(read_sample_datain), 0);
        chk({tag, "_cnt"},    32'(dut.u_cnt.count_q), 0);
        chk({tag, "_state"},  32'(dut.state_q), 32'(ST_IDLE));
    endtask

    // One read window. Called at a negedge with the DUT idle.
    task automatic run_window(input logic pri, input logic ar, input logic mr, input int n,
                              input bit arb_strobe, input bit coinc, input logic [1:0] g,
                              input bit exp_short, input bit exp_over);
        logic ab, mb, exp_bit;
        bit   fwd;
        pri_msp = pri; adc_ready = ar; msp_ready = mr;
        read_sample_ctl = 1'b1;
        @(negedge clk);
        chk("arb_src", 32'(src_sel), 32'(g));
        chk("arb_busy", 32'(busy), 1);
        chk("arb_actl", 32'(adc_ctl), 32'(g == 2'd1));
        chk("arb_mctl", 32'(msp_ctl), 32'(g == 2'd2));
        chk("arb_eshort_clr", 32'(err_short), 0);
        chk("arb_eover_clr", 32'(err_over), 0);
        if (arb_strobe) begin
            read_sample_clk = 1'b1;
            #1;
            chk("arb_strobe_aclk", 32'(adc_clk), 0);
            chk("arb_strobe_mclk", 32'(msp_clk), 0);
        end
        @(negedge clk);
        read_sample_clk = 1'b0;
        if (arb_strobe) chk("arb_strobe_eover", 32'(err_over), 1);
        for (int i = 1; i <= n; i++) begin
            if (i == 5) begin
                pri_msp = ~pri_msp; adc_ready = ~adc_ready; msp_ready = ~msp_ready;
            end
            ab = 1'($urandom); mb = 1'($urandom);
            adc_data = ab; msp_data = mb;
            read_sample_clk = 1'b1;
            if (coinc && i == n) read_sample_ctl = 1'b0;
            #1;
            fwd = (i <= NB);
            exp_bit = !fwd ? 1'b0 : (g == 2'd1) ? ab : (g == 2'd2) ? mb : 1'b0;
            chk("bit_aclk", 32'(adc_clk), 32'(fwd && g == 2'd1));
            chk("bit_mclk", 32'(msp_clk), 32'(fwd && g == 2'd2));
            chk("bit_din", 32'(read_sample_datain), 32'(exp_bit));
            chk("bit_src_lock", 32'(src_sel), 32'(g));
            @(negedge clk);
            read_sample_clk = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        if (n >= NB && !coinc) begin
            chk("hold_state", 32'(dut.state_q), 32'(ST_HOLD));
            chk("hold_src", 32'(src_sel), 32'(g));
            chk("hold_din", 32'(read_sample_datain), 0);
        end
        read_sample_ctl = 1'b0;
        repeat (2) @(negedge clk);
        chk("end_busy", 32'(busy), 0);
        chk("end_src", 32'(src_sel), 0);
        chk("end_cnt", 32'(dut.u_cnt.count_q), 0);
        chk("end_eshort", 32'(err_short), 32'(exp_short));
        chk("end_eover", 32'(err_over), 32'(exp_over));
    endtask

    typedef struct {
        logic       pri, ar, mr;
        int         n;
        bit         arb_strobe, coinc;
        logic [1:0] src;
        bit         sh, ov;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 16, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 16, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1,  9, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 17, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1,  9, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 16, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1};

        reset_n = 1'b0;
        read_sample_ctl = 1'b0; read_sample_clk = 1'b0;
        pri_msp = 1'b0; adc_ready = 1'b0; msp_ready = 1'b0;
        adc_data = 1'b0; msp_data = 1'b0;
        #1;
        chk_all_zero("rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);

        // Directed windows
        foreach (tbl[k]) begin
            run_window(tbl[k].pri, tbl[k].ar, tbl[k].mr, tbl[k].n, tbl[k].arb_strobe,
                       tbl[k].coinc, tbl[k].src, tbl[k].sh, tbl[k].ov);
        end

        // Strobe while idle sets the sticky overrun flag
        run_window(1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
        read_sample_clk = 1'b1;
        @(negedge clk);
        read_sample_clk = 1'b0;
        chk("idle_strobe_eover", 32'(err_over), 1);
        chk("idle_strobe_busy", 32'(busy), 0);
        @(negedge clk);
        chk("idle_eover_sticky", 32'(err_over), 1);

        // Reset mid-window after 5 strobes, with a strobe and data bit high
        pri_msp = 1'b0; adc_ready = 1'b1; msp_ready = 1'b0;
        read_sample_ctl = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            read_sample_clk = 1'b1;
            @(negedge clk);
            read_sample_clk = 1'b0;
        end
        adc_data = 1'b1;
        read_sample_clk = 1'b1;
        #1;
        chk("pre_rst_aclk", 32'(adc_clk), 1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        read_sample_clk = 1'b0;
        read_sample_ctl = 1'b0;
        @(negedge clk);
        run_window(1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);

        // Randomized windows against the reference model
        for (int w = 0; w < 40; w++) begin
            logic pr, a, m;
            int   nn;
            bit   as, co;
            pr = 1'($urandom); a = 1'($urandom); m = 1'($urandom);
            nn = int'($urandom_range(0, 19));
            as = ($urandom_range(0, 3) == 0);
            co = (nn > 0) && ($urandom_range(0, 2) == 0);
            run_window(pr, a, m, nn, as, co, ref_grant(pr, a, m),
                       nn < NB, (nn > NB) || as);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sample_arbiter.md
SAMPLE_ARBITER -- requirements
Module: sample_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 16, meaning sample bits per read window.
REQ-002 The block SHALL have parameter FILL_BIT, default 1'b0, meaning the bit returned when no source is granted.
REQ-003 Port clk, input, 1, the single block clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port read_sample_ctl, input, 1, high while the read responder's sample window is open.
REQ-006 Port read_sample_clk, input, 1, one-clk-wide strobe per sample bit requested, synchronous to clk.
REQ-007 Port read_sample_datain, output, 1, sample bit returned to the read responder.
REQ-008 Port pri_msp, input, 1: 1 means MSP430 is preferred, 0 means ADC is preferred.
REQ-009 Ports adc_ready and msp_ready, input, 1 each: the source has a sample available.
REQ-010 Ports adc_data and msp_data, input, 1 each: the current serial bit from each source.
REQ-011 Ports adc_ctl and msp_ctl, output, 1 each: the source is selected for the current window.
REQ-012 Ports adc_clk and msp_clk, output, 1 each: forwarded bit strobe to each source.
REQ-013 Port src_sel, output, 2: the granted source (0 none, 1 ADC, 2 MSP).
REQ-014 Port busy, output, 1: high in any state other than IDLE.
REQ-015 Ports err_short and err_over, output, 1 each: sticky window-error flags.

Function
REQ-016 The FSM SHALL have four states: IDLE, ARB, SHIFT and HOLD.
REQ-017 In IDLE, a high read_sample_ctl SHALL move the FSM to ARB on the next edge.
REQ-018 In ARB, the FSM SHALL register src_sel for one cycle and then enter SHIFT.
- The preferred source SHALL be granted if ready.
- Otherwise, the other source SHALL be granted if ready.
- Otherwise, src_sel SHALL be none.
REQ-019 The grant SHALL stay locked from ARB until the FSM returns to IDLE, regardless of changes on the ready inputs or pri_msp.
REQ-020 adc_ctl or msp_ctl SHALL be high, as granted, from ARB through HOLD, and low otherwise.
REQ-021 In SHIFT, the granted source's clk output SHALL equal read_sample_clk combinationally, and the other source's clk output SHALL be 0.
REQ-022 In SHIFT, each strobe SHALL increment a bit counter whose width is ceil(log2(NUM_BITS+1)).
REQ-023 read_sample_datain SHALL combinationally equal the granted source's data input, or FILL_BIT when src_sel is none.
REQ-024 On the NUM_BITS-th strobe, the FSM SHALL enter HOLD; this strobe SHALL still be forwarded.
REQ-025 In HOLD, strobes SHALL NOT be forwarded; any strobe SHALL set err_over, and read_sample_datain SHALL be FILL_BIT.
REQ-026 When read_sample_ctl is low in HOLD, the FSM SHALL go to IDLE and clear the counter and src_sel.
REQ-027 When read_sample_ctl falls in ARB or SHIFT with the count below NUM_BITS, the FSM SHALL set err_short, go to IDLE, and clear the counter.
REQ-028 A strobe arriving in IDLE or ARB SHALL be ignored and SHALL set err_over.
REQ-029 err_short and err_over SHALL clear only on reset, or on the IDLE-to-ARB transition.
REQ-030 A strobe coincident with the fall of read_sample_ctl in SHIFT SHALL be forwarded and counted before the abort is evaluated.

Reset
REQ-031 While reset_n is low, state SHALL be IDLE, and the counter, src_sel, busy, err_short, err_over, adc_ctl, msp_ctl, adc_clk, msp_clk and read_sample_datain SHALL all be 0.
REQ-032 Assertion of reset_n mid-window SHALL abort immediately without setting error flags.
REQ-033 After reset_n deasserts, the block SHALL need no initialization cycle.

Structure
REQ-034 Package sample_arbiter_pkg SHALL hold the state enum and the SRC_NONE/SRC_ADC/SRC_MSP encodings.
REQ-035 The bit counter, with its terminal-count compare, SHALL be the sub-module sample_bit_counter.
REQ-036 There SHALL be no other hierarchy.

Verification
REQ-037 Priority: pri_msp=0, both sources ready, 16 strobes -> src_sel=1, adc_clk pulses 16 times, msp_clk stays 0, HOLD reached, no errors.
REQ-038 Fallback: pri_msp=1, only adc_ready=1 -> src_sel=1; then neither ready -> src_sel=0 and read_sample_datain=FILL_BIT for all 16 bits.
REQ-039 Short window: read_sample_ctl drops after 9 strobes -> err_short=1, FSM in IDLE, counter=0.
REQ-040 Overrun: 17 strobes in a window -> 16 forwarded and err_over=1; a strobe during ARB also sets err_over.
REQ-041 Grant lock: the granted source's ready toggles mid-SHIFT -> src_sel unchanged and all 16 bits come from that source.
REQ-042 Reset: reset_n pulses low after 5 strobes -> all outputs 0 within the same cycle, and the next window arbitrates normally.
